// File: rtl/char_move_ctrl.sv
// Movement controller for one on-screen character: turns left/right/jump commands
// into a registered sprite position, facing, walk frame and motion state.
module char_move_ctrl #(
    parameter int X_W          = 10,
    parameter int Y_W          = 10,
    parameter int CNT_W        = 20,
    parameter int CHAR_W       = 64,
    parameter int CHAR_H       = 64,
    parameter int X_MAX        = 1023,
    parameter int Y_FLOOR      = 766,
    parameter int X_SPAWN      = 500,
    parameter int Y_SPAWN      = 702,
    parameter int MOVE_DIV     = 350000,
    parameter int AIR_DIV      = 650000,
    parameter int RISE_DIV0    = 200000,
    parameter int RISE_STEP    = 20000,
    parameter int RISE_DIV_MAX = 800000,
    parameter int FALL_DIV0    = 800000,
    parameter int FALL_STEP    = 20000,
    parameter int FALL_DIV_MIN = 150000,
    parameter int JUMP_HEIGHT  = 200,
    parameter int SLOW_ZONE    = 25,
    parameter int VAR_JUMP     = 1,
    parameter int ANIM_FRAMES  = 8,
    parameter int ANIM_PX      = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           left,
    input  logic                           right,
    input  logic                           jump,
    input  logic                           respawn,
    input  logic                           on_ground,
    input  logic                           head_blocked,
    output logic [X_W-1:0]                 x,
    output logic [Y_W-1:0]                 y,
    output logic                           facing,
    output logic                           airborne,
    output logic [$clog2(ANIM_FRAMES)-1:0] frame,
    output logic [2:0]                     state_o,
    output logic                           landed
);

    typedef enum logic [2:0] {
        SPAWN = 3'd0,
        IDLE  = 3'd1,
        MOVE  = 3'd2,
        JUMP  = 3'd3,
        FALL  = 3'd4
    } state_t;

    localparam int FR_W = $clog2(ANIM_FRAMES);
    localparam int PX_W = (ANIM_PX > 1) ? $clog2(ANIM_PX) : 1;
    localparam int CW1  = CNT_W + 1;

    localparam logic [X_W-1:0]   X_RMAX   = X_W'(X_MAX - CHAR_W + 1);
    localparam logic [X_W-1:0]   X_SP     = X_W'(X_SPAWN);
    localparam logic [Y_W-1:0]   Y_SP     = Y_W'(Y_SPAWN);
    localparam logic [Y_W-1:0]   Y_GND    = Y_W'(Y_FLOOR - CHAR_H + 1);
    localparam logic [Y_W-1:0]   RISE_LIM = Y_W'(JUMP_HEIGHT);
    localparam logic [Y_W-1:0]   SLOW_AT  = Y_W'(JUMP_HEIGHT - SLOW_ZONE);
    localparam logic [CNT_W-1:0] MOVE_D   = CNT_W'(MOVE_DIV);
    localparam logic [CNT_W-1:0] AIR_D    = CNT_W'(AIR_DIV);
    localparam logic [CNT_W-1:0] RISE_D0  = CNT_W'(RISE_DIV0);
    localparam logic [CNT_W-1:0] FALL_D0  = CNT_W'(FALL_DIV0);
    localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(ANIM_FRAMES - 1);
    localparam logic [PX_W-1:0]  PX_LAST  = PX_W'(ANIM_PX - 1);

    function automatic logic [CNT_W-1:0] rise_div_up(input logic [CNT_W-1:0] d);
        logic [CW1-1:0] s;
        s = {1'b0, d} + CW1'(RISE_STEP);
        if (s > CW1'(RISE_DIV_MAX)) return CNT_W'(RISE_DIV_MAX);
        return s[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] fall_div_down(input logic [CNT_W-1:0] d);
        logic [CW1-1:0] lim;
        lim = CW1'(FALL_DIV_MIN) + CW1'(FALL_STEP);
        if ({1'b0, d} < lim) return CNT_W'(FALL_DIV_MIN);
        return d - CNT_W'(FALL_STEP);
    endfunction

    function automatic logic [FR_W-1:0] next_frame(input logic [FR_W-1:0] f);
        return (f == FR_LAST) ? '0 : f + FR_W'(1);
    endfunction

    state_t           state_q, state_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [Y_W-1:0]   y_start_q, y_start_d;
    logic             facing_q, facing_d;
    logic             airborne_q, airborne_d;
    logic             landed_q, landed_d;
    logic [FR_W-1:0]  frame_q, frame_d;
    logic [PX_W-1:0]  px_q, px_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic [CNT_W-1:0] rise_div_q, rise_div_d;
    logic [CNT_W-1:0] fall_div_q, fall_div_d;

    logic             grounded, dir, moved;
    logic [CNT_W-1:0] hdiv;
    logic [Y_W-1:0]   rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SPAWN;
            x_q        <= X_SP;
            y_q        <= Y_SP;
            y_start_q  <= '0;
            facing_q   <= 1'b1;
            airborne_q <= 1'b0;
            landed_q   <= 1'b0;
            frame_q    <= '0;
            px_q       <= '0;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            rise_div_q <= RISE_D0;
            fall_div_q <= FALL_D0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            y_start_q  <= y_start_d;
            facing_q   <= facing_d;
            airborne_q <= airborne_d;
            landed_q   <= landed_d;
            frame_q    <= frame_d;
            px_q       <= px_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            rise_div_q <= rise_div_d;
            fall_div_q <= fall_div_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        y_start_d  = y_start_q;
        facing_d   = facing_q;
        landed_d   = 1'b0;
        frame_d    = frame_q;
        px_d       = px_q;
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        rise_div_d = rise_div_q;
        fall_div_d = fall_div_q;
        moved      = 1'b0;
        grounded   = on_ground | (y_q == Y_GND);
        dir        = left ^ right;
        hdiv       = (state_q == MOVE) ? MOVE_D : AIR_D;
        rise       = y_start_q - y_q;

        if (en) begin
            if (respawn) begin
                state_d    = SPAWN;
                x_d        = X_SP;
                y_d        = Y_SP;
                frame_d    = '0;
                px_d       = '0;
                hcnt_d     = '0;
                vcnt_d     = '0;
                rise_div_d = RISE_D0;
                fall_div_d = FALL_D0;
            end else begin
                // Horizontal stepping only exists while walking or airborne
                if (!(state_q inside {MOVE, JUMP, FALL}) || !dir) begin
                    hcnt_d = '0;
                end else if (hcnt_q >= hdiv) begin
                    hcnt_d = '0;
                    if (right && x_q < X_RMAX) begin
                        x_d   = x_q + X_W'(1);
                        moved = 1'b1;
                    end else if (left && x_q > '0) begin
                        x_d   = x_q - X_W'(1);
                        moved = 1'b1;
                    end
                end else begin
                    hcnt_d = hcnt_q + CNT_W'(1);
                end
                if (dir) facing_d = right;

                case (state_q)
                    SPAWN: state_d = FALL;
                    IDLE: begin
                        frame_d = '0;
                        if (jump && grounded) state_d = JUMP;
                        else if (dir)         state_d = MOVE;
                        else if (!grounded)   state_d = FALL;
                    end
                    MOVE: begin
                        if (moved) begin
                            if (px_q == PX_LAST) begin
                                px_d    = '0;
                                frame_d = next_frame(frame_q);
                            end else begin
                                px_d = px_q + PX_W'(1);
                            end
                        end
                        if (jump && grounded) state_d = JUMP;
                        else if (!grounded)   state_d = FALL;
                        else if (!dir)        state_d = IDLE;
                    end
                    JUMP: begin
                        if (moved) frame_d = next_frame(frame_q);
                        // Exit wins over a due step so the rise ends exactly where it stands
                        if (rise >= RISE_LIM || head_blocked || y_q == '0 ||
                            (VAR_JUMP != 0 && !jump)) begin
                            state_d = FALL;
                        end else if (vcnt_q >= rise_div_q) begin
                            y_d    = y_q - Y_W'(1);
                            vcnt_d = '0;
                            if (rise + Y_W'(1) >= SLOW_AT) rise_div_d = rise_div_up(rise_div_q);
                        end else begin
                            vcnt_d = vcnt_q + CNT_W'(1);
                        end
                    end
                    FALL: begin
                        if (grounded || y_q > Y_GND) begin
                            state_d  = IDLE;
                            landed_d = 1'b1;
                            frame_d  = '0;
                            if (y_q > Y_GND) y_d = Y_GND;
                        end else if (vcnt_q >= fall_div_q) begin
                            y_d        = y_q + Y_W'(1);
                            vcnt_d     = '0;
                            fall_div_d = fall_div_down(fall_div_q);
                        end else begin
                            vcnt_d = vcnt_q + CNT_W'(1);
                        end
                    end
                    default: state_d = IDLE;
                endcase

                if (state_d != state_q) begin
                    hcnt_d = '0;
                    vcnt_d = '0;
                    px_d   = '0;
                    if (state_d == JUMP) begin
                        y_start_d  = y_q;
                        rise_div_d = RISE_D0;
                    end
                    if (state_d == FALL) fall_div_d = FALL_D0;
                end
            end
        end
        airborne_d = (state_d == JUMP) || (state_d == FALL);
    end

    assign x        = x_q;
    assign y        = y_q;
    assign facing   = facing_q;
    assign airborne = airborne_q;
    assign frame    = frame_q;
    assign state_o  = state_q;
    assign landed   = landed_q;

endmodule

// File: tb/tb_char_move_ctrl.sv
// Bench for char_move_ctrl: directed scenarios plus random stimulus, every cycle
// compared against a behavioural movement model.
module tb_char_move_ctrl;

    localparam int X_SPAWN = 500;
    localparam int Y_SPAWN = 702;
    localparam int X_RMAX  = 960;
    localparam int Y_GND   = 703;
    localparam int MDIV    = 3;
    localparam int ADIV    = 5;
    localparam int RISE0   = 2;
    localparam int RISEMAX = 4;
    localparam int FALL0   = 4;
    localparam int FALLMIN = 1;
    localparam int JH      = 10;
    localparam int SLOWAT  = 7;
    localparam int S_SPAWN = 0, S_IDLE = 1, S_MOVE = 2, S_JUMP = 3, S_FALL = 4;

    logic clk, rst, en, left, right, jump, respawn, on_ground, head_blocked;
    logic [9:0] x, y;
    logic facing, airborne, landed;
    logic [2:0] frame, state_o;

    char_move_ctrl #(
        .MOVE_DIV(3), .AIR_DIV(5), .RISE_DIV0(2), .RISE_STEP(1), .RISE_DIV_MAX(4),
        .FALL_DIV0(4), .FALL_STEP(1), .FALL_DIV_MIN(1), .JUMP_HEIGHT(10), .SLOW_ZONE(3)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .left(left), .right(right), .jump(jump),
        .respawn(respawn), .on_ground(on_ground), .head_blocked(head_blocked),
        .x(x), .y(y), .facing(facing), .airborne(airborne), .frame(frame),
        .state_o(state_o), .landed(landed)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    bit chk_on = 0;

    // Model state: plain integers describing the character
    int mx, my, mface, mframe, ms, mair, mland, mh, mv, mpx, mys, mrd, mfd;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step_model();
        int ns, tgt, div, rz;
        bit d, gnd, moved;
        d     = left ^ right;
        gnd   = on_ground || (my == Y_GND);
        mland = 0;
        if (respawn) begin
            mx = X_SPAWN; my = Y_SPAWN; mframe = 0; ms = S_SPAWN;
            mh = 0; mv = 0; mpx = 0; mrd = RISE0; mfd = FALL0;
        end else begin
            moved = 0;
            if (ms == S_MOVE || ms == S_JUMP || ms == S_FALL) begin
                div = (ms == S_MOVE) ? MDIV : ADIV;
                if (!d) mh = 0;
                else if (mh >= div) begin
                    mh  = 0;
                    tgt = right ? mx + 1 : mx - 1;
                    if (tgt >= 0 && tgt <= X_RMAX) begin mx = tgt; moved = 1; end
                end else mh++;
            end else mh = 0;
            if (d) mface = right;
            ns = ms;
            case (ms)
                S_SPAWN: ns = S_FALL;
                S_IDLE: begin
                    mframe = 0;
                    if (jump && gnd) ns = S_JUMP;
                    else if (d) ns = S_MOVE;
                    else if (!gnd) ns = S_FALL;
                end
                S_MOVE: begin
                    if (moved) begin
                        mpx++;
                        if (mpx == 8) begin mpx = 0; mframe = (mframe + 1) % 8; end
                    end
                    if (jump && gnd) ns = S_JUMP;
                    else if (!gnd) ns = S_FALL;
                    else if (!d) ns = S_IDLE;
                end
                S_JUMP: begin
                    if (moved) mframe = (mframe + 1) % 8;
                    rz = mys - my;
                    if (rz >= JH || head_blocked || my == 0 || !jump) ns = S_FALL;
                    else if (mv >= mrd) begin
                        my--; mv = 0;
                        if (mys - my >= SLOWAT) mrd = (mrd + 1 > RISEMAX) ? RISEMAX : mrd + 1;
                    end else mv++;
                end
                S_FALL: begin
                    if (gnd) begin ns = S_IDLE; mland = 1; mframe = 0; end
                    else if (mv >= mfd) begin
                        my++; mv = 0;
                        mfd = (mfd - 1 < FALLMIN) ? FALLMIN : mfd - 1;
                    end else mv++;
                end
                default: ns = S_IDLE;
            endcase
            if (ns != ms) begin
                mh = 0; mv = 0; mpx = 0;
                if (ns == S_JUMP) begin mys = my; mrd = RISE0; end
                if (ns == S_FALL) mfd = FALL0;
            end
            ms = ns;
        end
        mair = (ms == S_JUMP || ms == S_FALL);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mx = X_SPAWN; my = Y_SPAWN; mface = 1; mframe = 0; ms = S_SPAWN; mair = 0;
            mland = 0; mh = 0; mv = 0; mpx = 0; mys = 0; mrd = RISE0; mfd = FALL0;
        end else if (!en) mland = 0;
        else step_model();
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("x", x, mx);
            check("y", y, my);
            check("facing", facing, mface);
            check("frame", frame, mframe);
            check("state", state_o, ms);
            check("airborne", airborne, mair);
            check("landed", landed, mland);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic land_wait();
        int n = 0;
        while (ms != S_IDLE && n < 400) begin tick(); n++; end
        check("land_reached", state_o, S_IDLE);
        jump = 0;
    endtask

    initial begin
        int n, ymin, sx, sy, sf, sfr, ss;
        clk = 0; rst = 0; en = 1; left = 0; right = 0; jump = 0; respawn = 0;
        on_ground = 0; head_blocked = 0;
        #2 rst = 1; chk_on = 1;
        #1;
        check("reset_x", x, 500);
        check("reset_y", y, 702);
        check("reset_state", state_o, 0);
        check("reset_frame", frame, 0);
        check("reset_facing", facing, 1);
        #9 rst = 0;
        tick();
        check("spawn_to_fall", state_o, 4);
        on_ground = 1;
        tick();
        check("land_idle", state_o, 1);
        check("land_pulse", landed, 1);
        tick();
        check("land_pulse_once", landed, 0);

        right = 1;
        repeat (41) tick();
        check("walk_x", x, 510);
        check("walk_frame", frame, 1);
        check("walk_facing", facing, 1);
        repeat (1900) tick();
        check("clamp_right_x", x, 960);
        left = 1;
        tick();
        check("conflict_idle", state_o, 1);
        left = 0; right = 0;

        jump = 1;
        tick();
        on_ground = 0;
        n = 0; ymin = 1023;
        while (state_o == 3 && n < 200) begin
            if (y < ymin) ymin = y;
            n++;
            tick();
        end
        check("jump_cycles", n, 36);
        check("jump_peak_y", ymin, 692);
        land_wait();
        check("jump_land_y", y, 703);
        check("jump_land_pulse", landed, 1);

        jump = 1;
        tick();
        n = 0;
        while ((mys - my) < 4 && n < 100) begin tick(); n++; end
        jump = 0;
        tick();
        check("varjump_fall", state_o, 4);
        check("varjump_y", y, 699);
        land_wait();

        jump = 1;
        tick();
        n = 0;
        while ((mys - my) < 2 && n < 100) begin tick(); n++; end
        head_blocked = 1;
        tick();
        check("bump_fall", state_o, 4);
        check("bump_y", y, 701);
        head_blocked = 0;
        land_wait();

        jump = 1;
        tick(); tick();
        jump = 0;
        tick();
        check("pre_respawn_fall", state_o, 4);
        tick();
        respawn = 1;
        tick();
        respawn = 0;
        check("respawn_x", x, 500);
        check("respawn_y", y, 702);
        check("respawn_state", state_o, 0);
        repeat (3) tick();

        sx = mx; sy = my; sf = mface; sfr = mframe; ss = ms;
        en = 0;
        for (int i = 0; i < 10; i++) begin
            left = $urandom_range(0, 1); right = $urandom_range(0, 1);
            jump = $urandom_range(0, 1); on_ground = $urandom_range(0, 1);
            tick();
            check("freeze_x", x, sx);
            check("freeze_y", y, sy);
            check("freeze_facing", facing, sf);
            check("freeze_frame", frame, sfr);
            check("freeze_state", state_o, ss);
            check("freeze_landed", landed, 0);
        end
        en = 1; on_ground = 0;

        for (int i = 0; i < 4000; i++) begin
            left         = ($urandom_range(0, 2) == 0);
            right        = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) jump = ~jump;
            on_ground    = ($urandom_range(0, 3) == 0);
            head_blocked = ($urandom_range(0, 15) == 0);
            respawn      = ($urandom_range(0, 299) == 0);
            en           = ($urandom_range(0, 15) != 0);
            tick();
        end
        en = 1; respawn = 0;
        tick();

        chk_on = 0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/char_move_ctrl.md
Name: char_move_ctrl

Overview:
- Parametrised movement controller for one on-screen character (Tom, Jerry or future NPCs). One instance per character.
- Converts left/right/jump commands into registered top-left (x, y) coordinates, facing, animation frame and motion state.
- Rise and fall speeds are accelerating. Jump height is variable, and respawn is supported.
- Collision status comes from an external platform checker through `on_ground` and `head_blocked`.

Parameters:
X_W, 10, x coordinate width
Y_W, 10, y coordinate width
CNT_W, 20, divider counter width
CHAR_W, 64, sprite width in px
CHAR_H, 64, sprite height in px
X_MAX, 1023, rightmost screen column
Y_FLOOR, 766, lowest row the sprite bottom may occupy
X_SPAWN, 500, spawn x
Y_SPAWN, 702, spawn y (Y_FLOOR-CHAR_H)
MOVE_DIV, 350000, ground horizontal divider
AIR_DIV, 650000, airborne horizontal divider
RISE_DIV0, 200000, initial rise divider
RISE_STEP, 20000, rise divider increment in slow zone
RISE_DIV_MAX, 800000, rise divider ceiling
FALL_DIV0, 800000, initial fall divider
FALL_STEP, 20000, fall divider decrement
FALL_DIV_MIN, 150000, fall divider floor
JUMP_HEIGHT, 200, maximum rise in px
SLOW_ZONE, 25, last px of the rise in which the rise decelerates
VAR_JUMP, 1, 1 = releasing jump ends the rise
ANIM_FRAMES, 8, frames per walk cycle
ANIM_PX, 8, ground px per frame advance

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en  in  1  0 = freeze all registers
left  in  1  move-left request
right  in  1  move-right request
jump  in  1  jump request (level)
respawn  in  1  return to spawn
on_ground  in  1  platform directly below sprite
head_blocked  in  1  platform directly above sprite
x  out  X_W  sprite left column
y  out  Y_W  sprite top row
facing  out  1  1 = right
airborne  out  1  state is JUMP or FALL
frame  out  $clog2(ANIM_FRAMES)  animation frame
state_o  out  3  SPAWN=0, IDLE=1, MOVE=2, JUMP=3, FALL=4
landed  out  1  one-cycle pulse on FALL→IDLE

Behaviour:
- All outputs are registered.
- Reset values: x=X_SPAWN, y=Y_SPAWN, facing=1, frame=0, state=SPAWN, airborne=0, landed=0. All counters are 0.
- Divider registers reset to RISE_DIV0 and FALL_DIV0.
- en=0: every register holds its value and landed is driven 0.
- Derived conditions:
  - grounded = on_ground | (y == Y_FLOOR-CHAR_H+1).
  - dir = exactly one of left/right is asserted. Both or neither means no direction.
- Horizontal stepping:
  - hcnt increments each cycle while dir is asserted.
  - When hcnt >= DIV and dir is asserted: x moves ±1 and hcnt clears. This gives one px per DIV+1 cycles.
  - DIV is MOVE_DIV in MOVE and AIR_DIV in JUMP/FALL, for both directions.
  - hcnt clears when dir is deasserted or on any state change.
- x is clamped to [0, X_MAX-CHAR_W+1]. A step at a bound leaves x unchanged; no wrap.
- Facing: right sets 1 and left sets 0, only while dir is asserted.
- State transitions:
  - respawn (any state): the next cycle loads x=X_SPAWN, y=Y_SPAWN, frame=0, state SPAWN. All counters clear. Respawn has the highest priority.
  - SPAWN → FALL unconditionally after 1 cycle. The divider loads FALL_DIV0.
  - IDLE:
    - jump & grounded → JUMP.
    - Else dir → MOVE.
    - Else !grounded → FALL.
    - Else stay in IDLE.
    - frame=0.
  - MOVE (jump has priority):
    - jump & grounded → JUMP.
    - Else !grounded → FALL.
    - Else !dir → IDLE.
    - frame advances mod ANIM_FRAMES every ANIM_PX px actually moved, tracked by a pixel counter. A clamped step does not count.
  - JUMP:
    - On entry: y_start=y, vcnt=0, rise_div=RISE_DIV0.
    - When vcnt >= rise_div: y decrements by 1 and vcnt clears.
    - If the new rise (y_start-y_new) >= JUMP_HEIGHT-SLOW_ZONE, rise_div increases by RISE_STEP, saturating at RISE_DIV_MAX.
    - Exit to FALL when any of: rise >= JUMP_HEIGHT, head_blocked, y==0, or (VAR_JUMP & !jump).
    - Exiting loads fall_div=FALL_DIV0 and clears vcnt.
    - Rise is computed unsigned, since y <= y_start always holds.
    - frame advances once per horizontal step.
  - FALL:
    - When vcnt >= fall_div: y increments by 1, vcnt clears, and fall_div decreases by FALL_STEP, saturating at FALL_DIV_MIN.
    - grounded → IDLE, landed=1 for one cycle, frame=0.
    - y never exceeds Y_FLOOR-CHAR_H+1; if the step would pass it, clamp and land.
- Simultaneous events:
  - left & right together count as no direction.
  - grounded and a due y-step in the same FALL cycle → land; y does not change.
  - In JUMP, when head_blocked and the height limit coincide, there is one transition to FALL.
  - Illegal state encodings go to IDLE with counters cleared.

Test Plan:
- Sim parameters: MOVE_DIV=3, AIR_DIV=5, RISE_DIV0=2, RISE_STEP=1, RISE_DIV_MAX=4, FALL_DIV0=4, FALL_STEP=1, FALL_DIV_MIN=1, JUMP_HEIGHT=10, SLOW_ZONE=3.
- Reset then respawn:
  - Stimulus: rst pulse mid-cycle, on_ground=1 from cycle 2.
  - Required: x=500, y=702 immediately. state SPAWN→FALL→IDLE. landed pulses once.
- Walk right then clamp:
  - Stimulus: right held 40 cycles.
  - Required: x increments every 4 cycles (10 px), frame=1 after 8 px, facing=1.
  - Stimulus: start at x=X_MAX-CHAR_W+1.
  - Required: x stays there.
- Full jump:
  - Stimulus: jump held, no blocks.
  - Required: y falls by 10, with rise_div 2 for the first 7 px then 3, 4, 4. FALL follows, then IDLE on reaching floor with landed=1.
- Variable jump:
  - Stimulus: release jump after 4 px of rise.
  - Required: FALL next cycle, rise stops at 4.
- Head bump:
  - Stimulus: head_blocked asserted at rise 2.
  - Required: FALL next cycle.
- Freeze, conflict and respawn mid-air:
  - Stimulus: en=0 for 10 cycles.
  - Required: all outputs are constant.
  - Stimulus: left&right together.
  - Required: MOVE→IDLE.
  - Stimulus: respawn during FALL.
  - Required: x=500, y=702, state SPAWN.
